// File: rtl/picoblaze_sample_pkg.sv
// Shared types and widths for the PicoBlaze sample server.
package picoblaze_sample_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned OUT_W    = 8;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    SERVE_HI  = 2'd3
  } state_e;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } half_e;

endpackage

// File: rtl/picoblaze_sample_server_sample_abs_scale.sv
// Signed 16-bit sample to 8-bit magnitude: |s| (with -32768 saturated to 32767), bits [14:7].
module sample_abs_scale
  import picoblaze_sample_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [OUT_W-1:0]    mag_o
);

  logic [SAMPLE_W-1:0] mag;

  always_comb begin
    mag = sample_i;
    if (sample_i[SAMPLE_W-1]) begin
      if (sample_i == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
        mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end else begin
        mag = SAMPLE_W'(~sample_i + SAMPLE_W'(1));
      end
    end
    mag_o = OUT_W'(mag >> 7);
  end

endmodule

// File: rtl/picoblaze_sample_server.sv
// Serves 8-bit magnitude samples to PicoBlaze, fetching packed 16-bit pairs from word memory.
// Optional SAMPLE_SERVER_OVERRUN_EN adds a sticky overrun flag for requests dropped while busy.
module picoblaze_sample_server
  import picoblaze_sample_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = ADDR_WIDTH'(23'h3FFFF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  get_new_addr,
  output logic [OUT_W-1:0]      sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic                  mem_waitrequest,
  input  logic [WORD_W-1:0]     mem_readdata,
  input  logic                  mem_readdatavalid
`ifdef SAMPLE_SERVER_OVERRUN_EN
  ,output logic                 overrun
`endif
);

  state_e                state_q, state_d;
  half_e                 half_q, half_d;
  logic                  gna_q;
  logic [SAMPLE_W-1:0]   hi_hold_q, hi_hold_d;
  logic [OUT_W-1:0]      sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_q, read_d;
  logic                  req;
  logic [OUT_W-1:0]      scale_lo, scale_hi;

  assign req = get_new_addr & ~gna_q;

  sample_abs_scale u_scale_lo (
    .sample_i (mem_readdata[SAMPLE_W-1:0]),
    .mag_o    (scale_lo)
  );

  sample_abs_scale u_scale_hi (
    .sample_i (hi_hold_q),
    .mag_o    (scale_hi)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      half_q    <= LOW;
      gna_q     <= 1'b0;
      hi_hold_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= START_ADDR;
      read_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      gna_q     <= get_new_addr;
      hi_hold_q <= hi_hold_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req) state_d = (half_q == LOW) ? REQ : SERVE_HI;
      REQ:       if (!mem_waitrequest) state_d = WAIT_DATA;
      WAIT_DATA: if (mem_readdatavalid) state_d = IDLE;
      SERVE_HI:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    half_d    = half_q;
    hi_hold_d = hi_hold_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    addr_d    = addr_q;
    read_d    = read_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          busy_d = 1'b1;
          read_d = (half_q == LOW);
        end
      end
      REQ: begin
        if (!mem_waitrequest) read_d = 1'b0;
      end
      WAIT_DATA: begin
        if (mem_readdatavalid) begin
          hi_hold_d = mem_readdata[WORD_W-1:SAMPLE_W];
          sample_d  = scale_lo;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          half_d    = HIGH;
        end
      end
      SERVE_HI: begin
        sample_d = scale_hi;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        half_d   = LOW;
        addr_d   = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_WIDTH'(1);
      end
      default: begin
        read_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

`ifdef SAMPLE_SERVER_OVERRUN_EN
  logic overrun_q;

  // Sticky record of any request arriving while a previous one is in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (req && busy_q) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign mem_addr     = addr_q;
  assign mem_read     = read_q;

endmodule

// File: tb/tb_picoblaze_sample_server.sv
// Randomized self-checking bench for picoblaze_sample_server against a behavioural sample model.
module tb_picoblaze_sample_server;

  localparam int unsigned AW    = 23;
  localparam logic [AW-1:0] START = 23'h10;
  localparam logic [AW-1:0] ENDA  = 23'h13;

  logic          clk;
  logic          reset_n;
  logic          get_new_addr;
  logic [7:0]    sample_out;
  logic          sample_valid;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_waitrequest;
  logic [31:0]   mem_readdata;
  logic          mem_readdatavalid;
`ifdef SAMPLE_SERVER_OVERRUN_EN
  logic          overrun;
`endif

  picoblaze_sample_server #(
    .ADDR_WIDTH (AW),
    .START_ADDR (START),
    .END_ADDR   (ENDA)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .get_new_addr      (get_new_addr),
    .sample_out        (sample_out),
    .sample_valid      (sample_valid),
    .busy              (busy),
    .mem_addr          (mem_addr),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
`ifdef SAMPLE_SERVER_OVERRUN_EN
    ,.overrun          (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Magnitude of a signed sample, clipped to 32767, divided by 128
  function automatic int ref_scale(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v / 128;
  endfunction

  // Memory contents and behavioural bus slave
  logic [31:0]   mem [4];
  int            wr_cfg  = 0;
  int            lat_cfg = 3;
  int            reads   = 0;
  bit            stray_go = 1'b0;
  logic [31:0]   stray_word = '0;
  logic [AW-1:0] last_acc_addr = '0;
  bit            acc, pending, in_read;
  int            cnt, wr_left;
  logic [AW-1:0] a_addr;
  logic [31:0]   pend_word;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) - int'(START);
    if (idx >= 0 && idx < 4) return mem[idx];
    return 32'hDEAD_BEEF;
  endfunction

  always begin
    @(posedge clk);
    acc    = reset_n && mem_read && !mem_waitrequest;
    a_addr = mem_addr;
    #1;
    mem_readdatavalid = 1'b0;
    if (!reset_n) begin
      pending = 1'b0;
      in_read = 1'b0;
      mem_waitrequest = 1'b0;
    end else begin
      if (pending) begin
        if (cnt <= 1) begin
          mem_readdatavalid = 1'b1;
          mem_readdata = pend_word;
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end else if (stray_go) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = stray_word;
        stray_go = 1'b0;
      end
      if (acc) begin
        reads++;
        last_acc_addr = a_addr;
        pending = 1'b1;
        cnt = lat_cfg;
        pend_word = mem_word(a_addr);
      end
      if (mem_read) begin
        if (!in_read) begin
          in_read = 1'b1;
          wr_left = wr_cfg;
        end
        mem_waitrequest = (wr_left > 0);
        if (wr_left > 0) wr_left--;
      end else begin
        in_read = 1'b0;
        mem_waitrequest = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference state: next word to serve and which half of it
  logic [AW-1:0] m_addr;
  bit            m_half;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == ENDA) ? START : a + AW'(1);
  endfunction

  task automatic serve(input int hold);
    logic [31:0] w;
    int exp, n, rd0, extra;
    bit hi, seen;
    hi   = m_half;
    w    = mem_word(m_addr);
    exp  = hi ? ref_scale(w[31:16]) : ref_scale(w[15:0]);
    rd0  = reads;
    seen = 1'b0;
    n    = 0;
    get_new_addr = 1'b1;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (n >= hold) get_new_addr = 1'b0;
      if (n == 1) begin
        check("busy_on", 32'(busy), 32'd1);
        check("read_on", 32'(mem_read), 32'(!hi));
      end
      if (mem_read) check("addr_stable", 32'(mem_addr), 32'(m_addr));
      if (sample_valid) seen = 1'b1;
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("sample", 32'(sample_out), 32'(exp));
    if (hi) check("hi_latency", 32'(n), 32'd2);
    else    check("fetch_addr", 32'(last_acc_addr), 32'(m_addr));
    check("busy_off", 32'(busy), 32'd0);
    if (hi) begin
      m_half = 1'b0;
      m_addr = next_addr(m_addr);
    end else begin
      m_half = 1'b1;
    end
    extra = 0;
    while (n < hold + 2) begin
      tick();
      n++;
      if (n >= hold) get_new_addr = 1'b0;
      if (sample_valid) extra++;
    end
    check("one_pulse", 32'(extra), 32'd0);
    check("sample_hold", 32'(sample_out), 32'(exp));
    check("reads", 32'(reads - rd0), hi ? 32'd0 : 32'd1);
    check("addr", 32'(mem_addr), 32'(m_addr));
  endtask

  initial begin
    int rd0, n, vcount;
    bit seen;
    int exp;
    reset_n = 1'b0;
    get_new_addr = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata = '0;
    mem_readdatavalid = 1'b0;
    mem[0] = 32'h8000_0100;
    mem[1] = 32'hFF80_4000;
    mem[2] = $urandom;
    mem[3] = $urandom;
    repeat (3) tick();
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(START));
`ifdef SAMPLE_SERVER_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif
    reset_n = 1'b1;
    tick();
    m_addr = START;
    m_half = 1'b0;

    // Directed words from the first two addresses
    lat_cfg = 3;
    wr_cfg  = 0;
    serve(1);
    check("tp_word0_lo", 32'(sample_out), 32'h02);
    serve(1);
    check("tp_word0_hi", 32'(sample_out), 32'hFF);
    check("tp_addr_inc", 32'(mem_addr), 32'(START + AW'(1)));
    serve(1);
    check("tp_word1_lo", 32'(sample_out), 32'h80);
    serve(1);
    check("tp_word1_hi", 32'(sample_out), 32'h01);

    // Stalled bus, then wrap from END_ADDR
    wr_cfg = 5;
    serve(1);
    serve(1);
    check("at_end", 32'(mem_addr), 32'(ENDA));
    serve(2);
    serve(1);
    check("wrap", 32'(mem_addr), 32'(START));

    // Long request level is a single request
    wr_cfg = 0;
    serve(10);
    serve(10);

    // Second rising edge during WAIT_DATA is dropped
    lat_cfg = 8;
    rd0 = reads;
    exp = ref_scale(mem_word(m_addr) & 32'hFFFF);
    get_new_addr = 1'b1;
    tick();
    get_new_addr = 1'b0;
    repeat (3) tick();
    get_new_addr = 1'b1;
    tick();
    get_new_addr = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      tick();
      n++;
      if (sample_valid) seen = 1'b1;
    end
    check("drop_valid", 32'(seen), 32'd1);
    check("drop_sample", 32'(sample_out), 32'(exp));
    m_half = 1'b1;
    repeat (4) tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_read", 32'(mem_read), 32'd0);
    check("drop_reads", 32'(reads - rd0), 32'd1);
`ifdef SAMPLE_SERVER_OVERRUN_EN
    check("overrun_set", 32'(overrun), 32'd1);
`endif
    serve(1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      wr_cfg  = $urandom_range(0, 3);
      lat_cfg = $urandom_range(1, 5);
      if (!m_half) mem[$urandom_range(0, 3)] = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      serve($urandom_range(1, 4));
    end
`ifdef SAMPLE_SERVER_OVERRUN_EN
    check("overrun_sticky", 32'(overrun), 32'd1);
`endif

    // Reset while a read is stalled
    if (m_half) serve(1);
    wr_cfg = 10;
    get_new_addr = 1'b1;
    tick();
    get_new_addr = 1'b0;
    tick();
    check("in_req_read", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_read", 32'(mem_read), 32'd0);
    check("mid_rst_sample", 32'(sample_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'(START));
`ifdef SAMPLE_SERVER_OVERRUN_EN
    check("mid_rst_overrun", 32'(overrun), 32'd0);
`endif
    reset_n = 1'b1;
    wr_cfg = 0;
    lat_cfg = 3;
    tick();
    m_addr = START;
    m_half = 1'b0;

    // Stray read data in IDLE is ignored
    stray_word = 32'h1234_5678;
    stray_go = 1'b1;
    vcount = 0;
    repeat (4) begin
      tick();
      if (sample_valid) vcount++;
    end
    check("stray_sample", 32'(sample_out), 32'd0);
    check("stray_valid", 32'(vcount), 32'd0);
    serve(1);
    serve(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
